// File: rtl/reset_sequencer_if.sv
// Handshake bundle for reset_sequencer: request/kick inputs, reset/status outputs.
// Watchdog signals exist only when RESET_SEQ_WDOG_EN is defined.
interface reset_sequencer_if #(
  parameter int unsigned NUM_OUT = 4
);
  logic               req_i;
  logic [NUM_OUT-1:0] rst_n_o;
  logic               busy_o;
  logic               done_o;
`ifdef RESET_SEQ_WDOG_EN
  logic               wdog_kick_i;
  logic               wdog_trip_o;

  modport master (
    input  req_i,
    input  wdog_kick_i,
    output rst_n_o,
    output busy_o,
    output done_o,
    output wdog_trip_o
  );

  modport slave (
    output req_i,
    output wdog_kick_i,
    input  rst_n_o,
    input  busy_o,
    input  done_o,
    input  wdog_trip_o
  );
`else
  modport master (
    input  req_i,
    output rst_n_o,
    output busy_o,
    output done_o
  );

  modport slave (
    output req_i,
    input  rst_n_o,
    input  busy_o,
    input  done_o
  );
`endif
endinterface

// File: rtl/reset_sequencer.sv
// Ordered reset release: hold all outputs low, then release them one by one in index order.
// Optional idle watchdog that restarts the sequence is enabled by RESET_SEQ_WDOG_EN.
module reset_sequencer #(
  parameter int unsigned NUM_OUT        = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned STAGGER_CYCLES = 4,
  parameter int unsigned WDOG_CYCLES    = 1024
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  reset_sequencer_if.master   seq_io
);

  typedef enum logic [1:0] {StAssert, StHold, StRelease, StIdle} state_e;

  localparam int unsigned CntMax = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned IdxW   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] StagLast = CntW'(STAGGER_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_OUT - 1);

  state_e             r_state;
  logic [CntW-1:0]    r_cnt;
  logic [IdxW-1:0]    r_idx;
  logic [NUM_OUT-1:0] r_rst_n;
  logic               r_busy;
  logic               r_done;

  logic               w_trip;
  logic               w_restart;
  logic [NUM_OUT-1:0] w_rel_mask;

  // A watchdog trip can only fire in idle, so it folds into the request path.
  assign w_restart  = seq_io.req_i | w_trip;
  assign w_rel_mask = NUM_OUT'(1) << r_idx;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= StAssert;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rst_n <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StAssert: begin
          r_state <= StHold;
          r_cnt   <= '0;
        end
        StHold: begin
          if (w_restart) begin
            r_rst_n <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
          end else if (r_cnt == HoldLast) begin
            r_rst_n[0] <= 1'b1;
            r_cnt      <= '0;
            if (NUM_OUT == 1) begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= StRelease;
              r_idx   <= IdxW'(1);
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StRelease: begin
          if (w_restart) begin
            r_state <= StHold;
            r_rst_n <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
          end else if (r_cnt == StagLast) begin
            r_rst_n <= r_rst_n | w_rel_mask;
            r_cnt   <= '0;
            if (r_idx == IdxLast) begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StIdle: begin
          if (w_restart) begin
            r_state <= StHold;
            r_rst_n <= '0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_idx   <= '0;
          end
        end
        default: begin
          r_state <= StAssert;
        end
      endcase
    end
  end

  assign seq_io.rst_n_o = r_rst_n;
  assign seq_io.busy_o  = r_busy;
  assign seq_io.done_o  = r_done;

`ifdef RESET_SEQ_WDOG_EN
  localparam int unsigned    WdW    = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WdW-1:0] WdTrip = WdW'(WDOG_CYCLES - 2);

  logic [WdW-1:0] r_wd;
  logic           r_trip;

  // Trips on the edge where the idle count would reach WDOG_CYCLES-1.
  assign w_trip = (r_state == StIdle) && !seq_io.wdog_kick_i && (r_wd == WdTrip);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wd   <= '0;
      r_trip <= 1'b0;
    end else begin
      r_trip <= w_trip;
      if ((r_state != StIdle) || w_trip || seq_io.req_i || seq_io.wdog_kick_i) begin
        r_wd <= '0;
      end else begin
        r_wd <= r_wd + 1'b1;
      end
    end
  end

  assign seq_io.wdog_trip_o = r_trip;
`else
  logic w_unused_wdog;

  assign w_trip        = 1'b0;
  assign w_unused_wdog = ^WDOG_CYCLES;
`endif

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Generates ordered, stretched, active-low reset outputs for downstream blocks that each locally synchronize their reset with a pulse stretcher. On power-on reset or a synchronous request it asserts all outputs, holds them for a programmable time, then releases them one at a time in index order with a fixed stagger. It is the source end of the reset network and sits at the top of each clock domain, ahead of the per-block reset synchronizers.

## Interface
- NUM_OUT, 4: number of reset outputs (>= 1)
- HOLD_CYCLES, 16: cycles all outputs stay low before the first release (>= 2)
- STAGGER_CYCLES, 4: cycles between consecutive output releases (>= 1)
- WDOG_CYCLES, 1024: watchdog timeout in cycles (>= 2; used only with RESET_SEQ_WDOG_EN)

- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- req_i  in  1  synchronous reset request, sampled each rising edge
- rst_n_o  out  NUM_OUT  active-low reset outputs; bit 0 is released first
- busy_o  out  1  high while any rst_n_o bit is low
- done_o  out  1  one-cycle pulse when the last output is released
- wdog_kick_i  in  1  watchdog kick (only with RESET_SEQ_WDOG_EN)
- wdog_trip_o  out  1  one-cycle pulse on watchdog timeout (only with RESET_SEQ_WDOG_EN)

## Operation
- States: ASSERT, HOLD, RELEASE, IDLE. There is one counter `cnt` and one release index `idx`.
- Reset (rst_n_i low) sets the outputs asynchronously: rst_n_o = all 0, busy_o = 1, done_o = 0, wdog_trip_o = 0, state = ASSERT, cnt = 0, idx = 0.
- ASSERT: on the next edge, go to HOLD with cnt = 0.
- HOLD: cnt increments each edge. At the edge where cnt == HOLD_CYCLES-1:
  - set rst_n_o[0] = 1.
  - If NUM_OUT == 1, go to IDLE. Otherwise go to RELEASE with idx = 1, cnt = 0.
- RELEASE: cnt increments each edge. At the edge where cnt == STAGGER_CYCLES-1:
  - set rst_n_o[idx] = 1 and cnt = 0.
  - If idx == NUM_OUT-1, go to IDLE. Otherwise idx increments.
- Entry into IDLE: busy_o falls and done_o pulses high for one cycle, both on the same edge that releases the last output.
- req_i high in IDLE: on that edge, rst_n_o = all 0, busy_o = 1, go to HOLD with cnt = 0.
- req_i high in HOLD or RELEASE (abort/restart):
  - on that edge, rst_n_o = all 0, go to HOLD with cnt = 0, idx reset.
  - The aborted sequence produces no done_o.
- req_i in ASSERT is ignored; ASSERT always proceeds to HOLD.
- Released bits are never re-asserted except by req_i, a watchdog trip, or rst_n_i.
- Counters are sized with $clog2 of their limit. Compares are exact equality, with no wrap-around past the limit.

## Timing
- Request at edge k:
  - rst_n_o goes to all 0 after edge k.
  - rst_n_o[i] rises at edge k + HOLD_CYCLES + i*STAGGER_CYCLES.
  - done_o is high for exactly the cycle following edge k + HOLD_CYCLES + (NUM_OUT-1)*STAGGER_CYCLES.
- Power-on: counting the first rising edge after rst_n_i deassertion as edge 1, rst_n_o[i] rises at edge 1 + HOLD_CYCLES + i*STAGGER_CYCLES.
- rst_n_i assertion mid-sequence: all outputs go low immediately (asynchronously), and the power-on timing then applies.
- All output deassertions are synchronous to clk_i. All outputs are registered, with no combinational paths from inputs to outputs.

## Configuration
- RESET_SEQ_WDOG_EN defined:
  - Adds wdog_kick_i, wdog_trip_o and a watchdog counter.
  - The counter is 0 outside IDLE and on entry to IDLE. In IDLE it increments each edge, and wdog_kick_i high clears it to 0.
  - At the edge where it reaches WDOG_CYCLES-1 without a kick, the block behaves exactly as a req_i in IDLE, and wdog_trip_o pulses for one cycle.
  - If req_i and a trip fall on the same edge, a single restart occurs and wdog_trip_o still pulses.
- RESET_SEQ_WDOG_EN undefined: the ports and counter are absent, and WDOG_CYCLES is unused.

## Test plan
All scenarios use the defaults unless stated.
- Power-on: release rst_n_i → rst_n_o releases as 0001, 0011, 0111, 1111 at edges 17, 21, 25, 29; done_o is high for one cycle after edge 29.
- Pulse req_i for 1 cycle at edge k in IDLE → rst_n_o = 0000 after k; bit 0 rises at k+16 and bit 3 at k+28; done_o pulses once.
- Assert req_i when rst_n_o = 0011 → all outputs low next edge; full sequence restarts with no done_o from the aborted run.
- Assert rst_n_i mid-RELEASE → rst_n_o = 0000 and busy_o = 1 immediately, before any clock edge; power-on timing resumes after release.
- NUM_OUT=1, HOLD_CYCLES=2 → req_i at edge k gives rst_n_o rising and done_o pulsing on edge k+2.
- RESET_SEQ_WDOG_EN, WDOG_CYCLES=8:
  - No kick → trip 7 edges after entering IDLE, followed by a full reset sequence.
  - Kicking every 5 cycles → no trip.
